// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV64I constants, opcode map and immediate format encoding
//   XLEN/ILEN       datapath and instruction widths (only 64/32 supported)
//   OPC_*           7-bit major opcodes of the RV64I base ISA
//   imm_fmt_t       immediate format code, 0=NONE 1=I 2=S 3=B 4=U 5=J
//   is_base_opc()   true for any RV64I base opcode (used by the optional illegal flag)
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    function automatic logic is_base_opc(input logic [6:0] opc);
        return opc inside {OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_STORE,
                           OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP32,
                           OPC_SYSTEM, OPC_FENCE};
    endfunction

endpackage

// File: rtl/riscv_imm_gen_if.sv
// riscv_imm_gen_if: decode-stage bus between instruction source and immediate generator
//   instruction  raw 32-bit instruction word (master -> slave)
//   imm          registered sign-extended immediate (slave -> master)
//   imm_fmt      registered format code (slave -> master)
//   illegal      registered illegal-opcode flag, only with IMM_GEN_ILLEGAL_FLAG_EN
interface riscv_imm_gen_if;
    import riscv_pkg::*;

    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] imm;
    imm_fmt_t        imm_fmt;
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    logic            illegal;

    modport master (output instruction, input imm, input imm_fmt, input illegal);
    modport slave  (input instruction, output imm, output imm_fmt, output illegal);
`else
    modport master (output instruction, input imm, input imm_fmt);
    modport slave  (input instruction, output imm, output imm_fmt);
`endif

endinterface

// File: rtl/riscv_imm_decode.sv
// riscv_imm_decode: combinational opcode-to-format map and raw immediate builder
//   i_instr  32-bit instruction word
//   o_fmt    immediate format for this opcode (IMM_NONE for R-type/system/unknown)
//   o_imm    sign-extended immediate, zero when o_fmt is IMM_NONE
module riscv_imm_decode
    import riscv_pkg::*;
(
    input  logic [ILEN-1:0] i_instr,
    output imm_fmt_t        o_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0] w_opc;
    logic       w_sign;

    assign w_opc  = i_instr[6:0];
    assign w_sign = i_instr[31];

    always_comb begin
        o_fmt = IMM_NONE;
        case (w_opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: o_fmt = IMM_I;
            OPC_STORE:                                    o_fmt = IMM_S;
            OPC_BRANCH:                                   o_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                           o_fmt = IMM_U;
            OPC_JAL:                                      o_fmt = IMM_J;
            default:                                      o_fmt = IMM_NONE;
        endcase
    end

    // Shift-immediates fall through as plain I-type; funct6 lands in imm[11:6].
    always_comb begin
        o_imm = '0;
        case (o_fmt)
            IMM_I: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:20]};
            IMM_S: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{(XLEN-13){w_sign}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: o_imm = {{(XLEN-32){w_sign}}, i_instr[31:12], 12'h000};
            IMM_J: o_imm = {{(XLEN-21){w_sign}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen: RV64I decode-stage immediate generator with one-cycle registered output
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears imm/imm_fmt (and illegal)
//   bus  riscv_imm_gen_if.slave: instruction in; imm, imm_fmt (illegal) out
// Optional feature macro: IMM_GEN_ILLEGAL_FLAG_EN adds the registered illegal flag.
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    riscv_imm_gen_if.slave  bus
);

    imm_fmt_t        w_fmt;
    logic [XLEN-1:0] w_imm;
    imm_fmt_t        r_fmt;
    logic [XLEN-1:0] r_imm;

    riscv_imm_decode u_decode (
        .i_instr (bus.instruction),
        .o_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imm <= '0;
            r_fmt <= IMM_NONE;
        end else begin
            r_imm <= w_imm;
            r_fmt <= w_fmt;
        end
    end

    assign bus.imm     = r_imm;
    assign bus.imm_fmt = r_fmt;

`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    logic w_illegal;
    logic r_illegal;

    // Compressed encodings (low bits != 11) are illegal for this RV64I-only decoder.
    assign w_illegal = (bus.instruction[1:0] != 2'b11) || !is_base_opc(bus.instruction[6:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_illegal <= 1'b0;
        else     r_illegal <= w_illegal;
    end

    assign bus.illegal = r_illegal;
`endif

endmodule

// File: tb/tb_riscv_imm_gen.sv
// tb_riscv_imm_gen: directed-vector self-checking bench for riscv_imm_gen
module tb_riscv_imm_gen;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    riscv_imm_gen_if bus ();

    riscv_imm_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    vec_t vecs [16] = '{
        '{32'h00500093, 64'h0000000000000005, 3'd1},
        '{32'hfff00093, 64'hFFFFFFFFFFFFFFFF, 3'd1},
        '{32'hfe000ce3, 64'hFFFFFFFFFFFFFFF8, 3'd3},
        '{32'h00113423, 64'h0000000000000008, 3'd2},
        '{32'h800000b7, 64'hFFFFFFFF80000000, 3'd4},
        '{32'h002081b3, 64'h0000000000000000, 3'd0},
        '{32'h12345017, 64'h0000000012345000, 3'd4},
        '{32'hffdff06f, 64'hFFFFFFFFFFFFFFFC, 3'd5},
        '{32'h00008067, 64'h0000000000000000, 3'd1},
        '{32'h4030d093, 64'h0000000000000403, 3'd1},
        '{32'h80002083, 64'hFFFFFFFFFFFFF800, 3'd1},
        '{32'hfe112e23, 64'hFFFFFFFFFFFFFFFC, 3'd2},
        '{32'h00000463, 64'h0000000000000008, 3'd3},
        '{32'h0010809b, 64'h0000000000000001, 3'd1},
        '{32'h00000073, 64'h0000000000000000, 3'd0},
        '{32'hffffffff, 64'h0000000000000000, 3'd0}
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] instr);
        @(negedge clk);
        bus.instruction = instr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.instruction = 32'hfff00093;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imm", bus.imm, 64'h0);
        check("rst_fmt", 64'(bus.imm_fmt), 64'h0);
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
        check("rst_illegal", 64'(bus.illegal), 64'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_imm", bus.imm, 64'hFFFFFFFFFFFFFFFF);
        check("first_fmt", 64'(bus.imm_fmt), 64'h1);
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].instr);
            check($sformatf("imm[%0d]", i), bus.imm, vecs[i].imm);
            check($sformatf("fmt[%0d]", i), 64'(bus.imm_fmt), 64'(vecs[i].fmt));
        end
        apply(32'h800000b7);
        #2;
        rst = 1'b1;
        #1;
        check("async_imm", bus.imm, 64'h0);
        check("async_fmt", 64'(bus.imm_fmt), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_imm", bus.imm, 64'hFFFFFFFF80000000);
        check("rel_fmt", 64'(bus.imm_fmt), 64'h4);
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
        apply(32'h00000000);
        check("ill_zero", 64'(bus.illegal), 64'h1);
        apply(32'h002081b3);
        check("ill_add", 64'(bus.illegal), 64'h0);
        apply(32'hffffffff);
        check("ill_ones", 64'(bus.illegal), 64'h1);
        apply(32'h0000000f);
        check("ill_fence", 64'(bus.illegal), 64'h0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
